if_controller: RTL and testbench

Input-feature-map (IF) address controller of the BNN convolution engine. After a `start` pulse it latches the layer configuration and walks every convolution window tap by tap, one tap per clock. For each tap it drives the ifmap BRAM read address, the one-hot channel enable and the data-source select. It also flags window start and first/last channel to the PE array and accumulators.

---
 rtl/if_controller.sv | 169 ++++++++++++++++
 tb/tb_if_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_controller.sv
// IF address controller: walks each convolution window tap by tap and emits ifmap read address, channel enable and source select.
// Define IF_CTRL_PAD_EN to enable zero-padding support; otherwise padding is ignored and every tap reads BRAM.
module if_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] image_size,
    input  logic [5:0]  number_channel,
    input  logic [3:0]  kernel_size,
    input  logic        padding,
    input  logic [1:0]  stride,
    input  logic        port_input,
    output logic [15:0] address_ifmap,
    output logic [31:0] channel_en,
    output logic [1:0]  input_choose,
    output logic        PE_start,
    output logic        first_channel,
    output logic        last_channel
);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t state;

    logic [15:0] img_q;
    logic [5:0]  nch_q;
    logic [3:0]  ks_q;
    logic [1:0]  strd_q;
    logic        port_q;
    logic [16:0] osz_q;

    logic [16:0] oy, ox, n_oy, n_ox;
    logic [5:0]  c, n_c;
    logic [3:0]  ky, kx, n_ky, n_kx;
    logic        last_tap;

    logic [5:0]  s_nch;
    logic [3:0]  s_ks;
    logic [1:0]  s_strd;
    logic        s_pad;
    logic signed [17:0] s_num;
    logic [16:0] s_osz;

    logic [15:0] e_img;
    logic [5:0]  e_nch;
    logic [1:0]  e_strd;
    logic        e_port;
    logic        in_range;
    logic [15:0] row, col, tap_addr;
    logic [1:0]  tap_sel;

`ifdef IF_CTRL_PAD_EN
    logic        pad_q;
    logic        e_pad;
    logic signed [17:0] iy, ix;
    assign s_pad = padding;
`else
    logic unused_padding;
    assign unused_padding = padding;
    assign s_pad = 1'b0;
`endif

    always_comb begin
        s_nch  = (number_channel == 6'd0) ? 6'd1 :
                 (number_channel > 6'd32) ? 6'd32 : number_channel;
        s_ks   = (kernel_size == 4'd0) ? 4'd1 : kernel_size;
        s_strd = (stride == 2'd0) ? 2'd1 : stride;
        s_num  = $signed({2'b00, image_size}) + $signed({16'd0, s_pad, 1'b0})
                 - $signed({14'd0, s_ks});
        // A kernel larger than the padded image yields no windows at all
        s_osz  = s_num[17] ? 17'd0 : 17'(s_num[16:0] / {15'd0, s_strd}) + 17'd1;
    end

    // In IDLE the first tap is computed straight from the incoming config
    always_comb begin
        e_img  = (state == IDLE) ? image_size : img_q;
        e_nch  = (state == IDLE) ? s_nch      : nch_q;
        e_strd = (state == IDLE) ? s_strd     : strd_q;
        e_port = (state == IDLE) ? port_input : port_q;
`ifdef IF_CTRL_PAD_EN
        e_pad  = (state == IDLE) ? s_pad      : pad_q;
`endif
    end

    always_comb begin
        n_kx = '0; n_ky = '0; n_c = '0; n_ox = '0; n_oy = '0;
        last_tap = 1'b0;
        if (state == SCAN) begin
            n_kx = kx + 4'd1; n_ky = ky; n_c = c; n_ox = ox; n_oy = oy;
            if (kx == ks_q - 4'd1) begin
                n_kx = '0;
                n_ky = ky + 4'd1;
                if (ky == ks_q - 4'd1) begin
                    n_ky = '0;
                    n_c  = c + 6'd1;
                    if (c == nch_q - 6'd1) begin
                        n_c  = '0;
                        n_ox = ox + 17'd1;
                        if (ox == osz_q - 17'd1) begin
                            n_ox     = '0;
                            n_oy     = oy + 17'd1;
                            last_tap = (oy == osz_q - 17'd1);
                        end
                    end
                end
            end
        end
    end

    always_comb begin
`ifdef IF_CTRL_PAD_EN
        iy = $signed({1'b0, n_oy} * {16'd0, e_strd} + {14'd0, n_ky} - {17'd0, e_pad});
        ix = $signed({1'b0, n_ox} * {16'd0, e_strd} + {14'd0, n_kx} - {17'd0, e_pad});
        in_range = !iy[17] && !ix[17] &&
                   (iy[16:0] < {1'b0, e_img}) && (ix[16:0] < {1'b0, e_img});
        row = iy[15:0];
        col = ix[15:0];
`else
        in_range = 1'b1;
        row = n_oy[15:0] * {14'd0, e_strd} + {12'd0, n_ky};
        col = n_ox[15:0] * {14'd0, e_strd} + {12'd0, n_kx};
`endif
        tap_addr = in_range ? ({10'd0, n_c} * e_img * e_img + row * e_img + col) : 16'd0;
        tap_sel  = in_range ? {1'b0, e_port} : 2'd2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            oy <= '0; ox <= '0; c <= '0; ky <= '0; kx <= '0;
            address_ifmap <= '0; channel_en <= '0; input_choose <= '0;
            PE_start <= 1'b0; first_channel <= 1'b0; last_channel <= 1'b0;
        end else begin
            oy <= n_oy; ox <= n_ox; c <= n_c; ky <= n_ky; kx <= n_kx;
            case (state)
                IDLE: begin
                    if (start && s_osz != 17'd0) begin
                        state  <= SCAN;
                        img_q  <= image_size;
                        nch_q  <= s_nch;
                        ks_q   <= s_ks;
                        strd_q <= s_strd;
                        port_q <= port_input;
                        osz_q  <= s_osz;
`ifdef IF_CTRL_PAD_EN
                        pad_q  <= s_pad;
`endif
                    end
                end
                SCAN: begin
                    if (last_tap) begin
                        state <= IDLE;
                        oy <= '0; ox <= '0; c <= '0; ky <= '0; kx <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
            if ((state == IDLE && start && s_osz != 17'd0) || (state == SCAN && !last_tap)) begin
                address_ifmap <= tap_addr;
                channel_en    <= 32'd1 << n_c;
                input_choose  <= tap_sel;
                PE_start      <= (n_c == 6'd0) && (n_ky == 4'd0) && (n_kx == 4'd0);
                first_channel <= (n_c == 6'd0);
                last_channel  <= (n_c == e_nch - 6'd1);
            end else begin
                address_ifmap <= '0; channel_en <= '0; input_choose <= '0;
                PE_start <= 1'b0; first_channel <= 1'b0; last_channel <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_if_controller.sv
// Self-checking bench for if_controller: directed and randomized scans against a loop-nest reference model.
module tb_if_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] image_size = '0;
    logic [5:0]  number_channel = '0;
    logic [3:0]  kernel_size = '0;
    logic        padding = 1'b0;
    logic [1:0]  stride = '0;
    logic        port_input = 1'b0;
    logic [15:0] address_ifmap;
    logic [31:0] channel_en;
    logic [1:0]  input_choose;
    logic        PE_start;
    logic        first_channel;
    logic        last_channel;

    if_controller dut (
        .clk(clk), .rst(rst), .start(start),
        .image_size(image_size), .number_channel(number_channel),
        .kernel_size(kernel_size), .padding(padding), .stride(stride),
        .port_input(port_input), .address_ifmap(address_ifmap),
        .channel_en(channel_en), .input_choose(input_choose),
        .PE_start(PE_start), .first_channel(first_channel),
        .last_channel(last_channel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] chen;
        logic [1:0]  sel;
        logic        pe;
        logic        fc;
        logic        lc;
    } tap_t;

    typedef struct {
        int img; int nch; int k; int pad; int s; int port;
    } cfg_t;

    tap_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic tap_t observe();
        return {address_ifmap, channel_en, input_choose, PE_start, first_channel, last_channel};
    endfunction

    // Reference: the spec's loop nest written out directly with integer arithmetic
    task automatic build_model(input cfg_t cf);
        int cc, kk, ss, pp, oo, iy, ix;
        longint a;
        tap_t t;
        exp_q.delete();
        ss = (cf.s == 0) ? 1 : cf.s;
        kk = (cf.k == 0) ? 1 : cf.k;
        cc = (cf.nch == 0) ? 1 : ((cf.nch > 32) ? 32 : cf.nch);
`ifdef IF_CTRL_PAD_EN
        pp = cf.pad;
`else
        pp = 0;
`endif
        oo = (cf.img + 2 * pp - kk) / ss + 1;
        for (int oy = 0; oy < oo; oy++)
            for (int ox = 0; ox < oo; ox++)
                for (int ch = 0; ch < cc; ch++)
                    for (int ky = 0; ky < kk; ky++)
                        for (int kx = 0; kx < kk; kx++) begin
                            iy = oy * ss + ky - pp;
                            ix = ox * ss + kx - pp;
                            t.chen = 32'h1 << ch;
                            t.pe = (ch == 0 && ky == 0 && kx == 0);
                            t.fc = (ch == 0);
                            t.lc = (ch == cc - 1);
                            if (iy < 0 || ix < 0 || iy >= cf.img || ix >= cf.img) begin
                                t.addr = 16'd0;
                                t.sel  = 2'd2;
                            end else begin
                                a = longint'(ch) * cf.img * cf.img + longint'(iy) * cf.img + ix;
                                t.addr = a[15:0];
                                t.sel  = cf.port[0] ? 2'd1 : 2'd0;
                            end
                            exp_q.push_back(t);
                        end
    endtask

    task automatic drive_cfg(input cfg_t cf);
        image_size     = 16'(cf.img);
        number_channel = 6'(cf.nch);
        kernel_size    = 4'(cf.k);
        padding        = cf.pad[0];
        stride         = 2'(cf.s);
        port_input     = cf.port[0];
    endtask

    task automatic scramble();
        image_size     = 16'($urandom);
        number_channel = 6'($urandom);
        kernel_size    = 4'($urandom);
        padding        = 1'($urandom);
        stride         = 2'($urandom);
        port_input     = 1'($urandom);
    endtask

    // Launches (unless already launched by a chained start) and checks every tap plus the idle cycle after
    task automatic run_check(input string name, input cfg_t cf, input bit pre, input bit chain,
                             input cfg_t nxt, input int mid, output int pe_dut);
        tap_t got;
        int n, pe_exp;
        build_model(cf);
        n = exp_q.size();
        if (!pre) begin
            @(posedge clk); #1;
            drive_cfg(cf);
            start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        pe_dut = 0; pe_exp = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            got = observe();
            vectors++;
            if (got !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s tap %0d: got %h want %h", name, i, got, exp_q[i]);
            end
            pe_dut += int'(PE_start);
            pe_exp += int'(exp_q[i].pe);
            start = (i == mid);
        end
        @(negedge clk);
        got = observe();
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL %s idle_after: got %h want 0", name, got);
        end
        vectors++;
        if (pe_dut != pe_exp) begin
            miscompares++;
            $display("FAIL %s pe_count: got %0d want %0d", name, pe_dut, pe_exp);
        end
        if (chain) begin
            drive_cfg(nxt);
            start = 1'b1;
        end
    endtask

    task automatic test_reset();
        tap_t got;
        rst = 1'b1; start = 1'b1;
        drive_cfg('{4, 1, 1, 0, 1, 0});
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = observe();
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", got);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        got = observe();
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL reset_stays_idle: got %h want 0", got);
        end
    endtask

    task automatic test_pad28();
        cfg_t cf;
        int pe;
        cf = '{28, 1, 3, 1, 1, 0};
        run_check("pad28", cf, 1'b0, 1'b0, cf, -1, pe);
        vectors++;
`ifdef IF_CTRL_PAD_EN
        if (pe != 784) begin
            miscompares++;
            $display("FAIL pad28_pe_total: got %0d want 784", pe);
        end
`else
        if (pe != 676) begin
            miscompares++;
            $display("FAIL pad28_pe_total: got %0d want 676", pe);
        end
`endif
    endtask

    task automatic test_back_to_back();
        cfg_t a, b;
        int pe;
        a = '{4, 2, 2, 0, 2, 0};
        b = '{4, 2, 2, 0, 2, 1};
        run_check("stride2_a", a, 1'b0, 1'b1, b, -1, pe);
        run_check("stride2_b", b, 1'b1, 1'b0, b, -1, pe);
    endtask

    task automatic test_mid_start();
        cfg_t cf;
        int pe;
        cf = '{5, 3, 2, 1, 1, 1};
        run_check("mid_start", cf, 1'b0, 1'b0, cf, 7, pe);
    endtask

    task automatic test_reset_mid();
        cfg_t cf;
        tap_t got;
        int pe;
        cf = '{4, 2, 2, 0, 2, 0};
        build_model(cf);
        @(posedge clk); #1;
        drive_cfg(cf);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            got = observe();
            vectors++;
            if (got !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rst_mid tap %0d: got %h want %h", i, got, exp_q[i]);
            end
        end
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        got = observe();
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_clear: got %h want 0", got);
        end
        @(negedge clk);
        got = observe();
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_idle: got %h want 0", got);
        end
        run_check("rst_restart", cf, 1'b0, 1'b0, cf, -1, pe);
    endtask

    task automatic test_sanitise();
        cfg_t cf;
        int pe;
        cf = '{4, 1, 0, 0, 0, 0};
        run_check("stride0_k0", cf, 1'b0, 1'b0, cf, -1, pe);
        cf = '{3, 0, 2, 1, 1, 0};
        run_check("nch0", cf, 1'b0, 1'b0, cf, -1, pe);
        cf = '{2, 45, 1, 0, 1, 1};
        run_check("nch_over", cf, 1'b0, 1'b0, cf, -1, pe);
    endtask

    task automatic test_random();
        cfg_t cf;
        int pe, kmax;
        for (int r = 0; r < 8; r++) begin
            cf.img  = $urandom_range(2, 8);
            kmax    = (cf.img < 6) ? cf.img : 6;
            cf.k    = $urandom_range(0, kmax);
            cf.nch  = $urandom_range(0, 40);
            cf.pad  = $urandom_range(0, 1);
            cf.s    = $urandom_range(0, 3);
            cf.port = $urandom_range(0, 1);
            build_model(cf);
            if (exp_q.size() > 4000) cf.nch = $urandom_range(1, 3);
            run_check("random", cf, 1'b0, 1'b0, cf, $urandom_range(0, 3) == 0 ? 3 : -1, pe);
        end
    endtask

    initial begin
        test_reset();
        test_pad28();
        test_back_to_back();
        test_mid_start();
        test_reset_mid();
        test_sanitise();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
